// File: rtl/amiga_clk_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : amiga_clk_seq                                                 |
// | Summary  : PLL restart, PAL/NTSC switch and lock-qualified system reset  |
// |            sequencer running on the board reference clock.               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module amiga_clk_seq #(
  parameter int CNT_W      = 16,
  parameter int PLLRST_LEN = 16,
  parameter int LOCK_TMO   = 65535,
  parameter int LOCK_WAIT  = 1024,
  parameter int RST_LEN    = 4096,
  parameter int DEB_LEN    = 8192
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       ntsc_sel,
  input  logic       btn_rst_n,
  output logic       pll_rst,
  output logic       ntsc,
  output logic       sys_rst,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_PLLRST   = 3'd0,
    S_WAITLOCK = 3'd1,
    S_SETTLE   = 3'd2,
    S_RESET    = 3'd3,
    S_RUN      = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] c_one         = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_pllrst_last = CNT_W'(PLLRST_LEN - 1);
  localparam logic [CNT_W-1:0] c_tmo_last    = CNT_W'(LOCK_TMO - 1);
  localparam logic [CNT_W-1:0] c_wait_last   = CNT_W'(LOCK_WAIT - 1);
  localparam logic [CNT_W-1:0] c_rst_last    = CNT_W'(RST_LEN - 1);
  localparam logic [CNT_W-1:0] c_deb_len     = CNT_W'(DEB_LEN);

  logic [1:0]       r_lock_sync;
  logic [1:0]       r_ntsc_sync;
  logic [1:0]       r_btn_sync;
  logic             w_locked_s;
  logic             w_ntsc_s;
  logic             w_btn_s;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             w_to_pllrst;

  logic [CNT_W-1:0] r_mode_cnt;
  logic             w_mode_diff;
  logic             w_mode_pend;

  logic [CNT_W-1:0] r_btn_cnt;
  logic             r_btn_held;
  logic             w_btn_match;
  logic             w_btn_done;
  logic             w_press;

  logic             r_pll_rst;
  logic             r_ntsc;
  logic             r_sys_rst;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_sync <= 2'b00;
      r_ntsc_sync <= 2'b00;
      r_btn_sync  <= 2'b00;
    end else begin
      r_lock_sync <= {r_lock_sync[0], pll_locked};
      r_ntsc_sync <= {r_ntsc_sync[0], ntsc_sel};
      r_btn_sync  <= {r_btn_sync[0], btn_rst_n};
    end
  end

  assign w_locked_s  = r_lock_sync[1];
  assign w_ntsc_s    = r_ntsc_sync[1];
  assign w_btn_s     = r_btn_sync[1];
  assign w_to_pllrst = (w_next == S_PLLRST);

  // Mode change: consecutive cycles of requested != applied, saturating.
  assign w_mode_diff = (w_ntsc_s != r_ntsc);
  assign w_mode_pend = (r_mode_cnt == c_deb_len);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_mode_cnt <= '0;
    end else if (w_to_pllrst || !w_mode_diff) begin
      r_mode_cnt <= '0;
    end else if (r_mode_cnt != c_deb_len) begin
      r_mode_cnt <= r_mode_cnt + c_one;
    end
  end

  // Button: count cycles at the awaited level (0 when armed, 1 when held),
  // flipping the held flag each time a full debounce period completes.
  assign w_btn_match = (w_btn_s == r_btn_held);
  assign w_btn_done  = (r_btn_cnt == c_deb_len);
  assign w_press     = w_btn_done && !r_btn_held;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_cnt  <= '0;
      r_btn_held <= 1'b0;
    end else if (w_to_pllrst) begin
      r_btn_cnt  <= '0;
      r_btn_held <= 1'b0;
    end else if (w_btn_done) begin
      r_btn_cnt  <= '0;
      r_btn_held <= !r_btn_held;
    end else if (!w_btn_match) begin
      r_btn_cnt  <= '0;
    end else begin
      r_btn_cnt  <= r_btn_cnt + c_one;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_PLLRST: begin
        if (r_cnt == c_pllrst_last) w_next = S_WAITLOCK;
      end
      S_WAITLOCK: begin
        if (w_locked_s)                w_next = S_SETTLE;
        else if (r_cnt == c_tmo_last)  w_next = S_PLLRST;
      end
      S_SETTLE: begin
        if (!w_locked_s)               w_next = S_WAITLOCK;
        else if (w_mode_pend)          w_next = S_PLLRST;
        else if (r_cnt == c_wait_last) w_next = S_RESET;
      end
      S_RESET: begin
        if (!w_locked_s)               w_next = S_WAITLOCK;
        else if (w_mode_pend)          w_next = S_PLLRST;
        else if (r_cnt == c_rst_last)  w_next = S_RUN;
      end
      S_RUN: begin
        if (!w_locked_s)               w_next = S_WAITLOCK;
        else if (w_mode_pend)          w_next = S_PLLRST;
        else if (w_press)              w_next = S_RESET;
      end
      default: w_next = S_PLLRST;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_PLLRST;
    end else begin
      r_state <= w_next;
    end
  end

  // RUN has no time limit, so the counter is parked there instead of wrapping.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_next != r_state) begin
      r_cnt <= '0;
    end else if (r_state != S_RUN) begin
      r_cnt <= r_cnt + c_one;
    end
  end

  // Outputs decode the next state so they move on the same edge as state.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_pll_rst <= 1'b1;
      r_sys_rst <= 1'b1;
      r_ntsc    <= 1'b0;
    end else begin
      r_pll_rst <= w_to_pllrst;
      r_sys_rst <= (w_next != S_RUN);
      if (w_to_pllrst) begin
        r_ntsc <= w_ntsc_s;
      end
    end
  end

  assign pll_rst = r_pll_rst;
  assign ntsc    = r_ntsc;
  assign sys_rst = r_sys_rst;
  assign state   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_amiga_clk_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_amiga_clk_seq                                              |
// | Summary  : Directed bench for amiga_clk_seq with a per-cycle model.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_amiga_clk_seq;

  localparam int PLLRST_LEN = 4;
  localparam int LOCK_TMO   = 32;
  localparam int LOCK_WAIT  = 8;
  localparam int RST_LEN    = 16;
  localparam int DEB_LEN    = 4;

  logic       clk_in     = 1'b0;
  logic       rst_n      = 1'b0;
  logic       pll_locked = 1'b1;
  logic       ntsc_sel   = 1'b1;
  logic       btn_rst_n  = 1'b1;
  logic       pll_rst;
  logic       ntsc;
  logic       sys_rst;
  logic [2:0] state;

  int n_checks = 0;
  int n_errors = 0;

  amiga_clk_seq #(
    .CNT_W     (16),
    .PLLRST_LEN(PLLRST_LEN),
    .LOCK_TMO  (LOCK_TMO),
    .LOCK_WAIT (LOCK_WAIT),
    .RST_LEN   (RST_LEN),
    .DEB_LEN   (DEB_LEN)
  ) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .pll_locked(pll_locked),
    .ntsc_sel  (ntsc_sel),
    .btn_rst_n (btn_rst_n),
    .pll_rst   (pll_rst),
    .ntsc      (ntsc),
    .sys_rst   (sys_rst),
    .state     (state)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: state = phase number, m_t = cycles already spent in it.
  int m_state, m_t, m_mode_run, m_btn_run;
  bit m_pll_rst, m_ntsc, m_sys_rst, m_btn_await_release;
  bit m_lk1, m_lk, m_ns1, m_ns, m_bt1, m_bt;

  task automatic model_reset();
    m_state = 0; m_t = 0; m_pll_rst = 1; m_ntsc = 0; m_sys_rst = 1;
    m_lk1 = 0; m_lk = 0; m_ns1 = 0; m_ns = 0; m_bt1 = 0; m_bt = 0;
    m_mode_run = 0; m_btn_run = 0; m_btn_await_release = 0;
  endtask

  task automatic model_step();
    int nxt;
    bit pend, press, rearm;
    pend  = (m_mode_run >= DEB_LEN);
    press = !m_btn_await_release && (m_btn_run >= DEB_LEN);
    rearm = m_btn_await_release && (m_btn_run >= DEB_LEN);
    nxt   = m_state;
    if (m_state == 0) begin
      if (m_t + 1 == PLLRST_LEN) nxt = 1;
    end else if (m_state == 1) begin
      if (m_lk) nxt = 2;
      else if (m_t + 1 == LOCK_TMO) nxt = 0;
    end else if (m_state <= 4) begin
      if (!m_lk) nxt = 1;
      else if (pend) nxt = 0;
      else if (m_state == 2 && m_t + 1 == LOCK_WAIT) nxt = 3;
      else if (m_state == 3 && m_t + 1 == RST_LEN) nxt = 4;
      else if (m_state == 4 && press) nxt = 3;
    end else begin
      nxt = 0;
    end
    if (m_ns != m_ntsc) m_mode_run = (m_mode_run < DEB_LEN) ? m_mode_run + 1 : DEB_LEN;
    else m_mode_run = 0;
    if (press || rearm) begin
      m_btn_await_release = !m_btn_await_release;
      m_btn_run = 0;
    end else if (m_bt == m_btn_await_release) begin
      m_btn_run++;
    end else begin
      m_btn_run = 0;
    end
    if (nxt == 0) begin
      m_ntsc = m_ns;
      m_mode_run = 0;
      m_btn_run = 0;
      m_btn_await_release = 0;
    end
    m_t       = (nxt == m_state) ? m_t + 1 : 0;
    m_state   = nxt;
    m_pll_rst = (nxt == 0);
    m_sys_rst = (nxt != 4);
    m_lk = m_lk1; m_lk1 = pll_locked;
    m_ns = m_ns1; m_ns1 = ntsc_sel;
    m_bt = m_bt1; m_bt1 = btn_rst_n;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk_in or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial begin
    repeat (2) @(posedge clk_in);
    forever begin
      @(negedge clk_in);
      #1;
      check("cycle", {26'd0, pll_rst, ntsc, sys_rst, state},
            {26'd0, m_pll_rst, m_ntsc, m_sys_rst, m_state[2:0]});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk_in);
  endtask

  task automatic wait_run(input string name);
    int k;
    k = 0;
    while (state != 3'd4 && k < 300) begin
      tick();
      k++;
    end
    check(name, state, 3'd4);
    repeat (3) tick();
  endtask

  initial begin
    int pll_fall, sys_fall, ntsc_at, st_at, first_k, entries, cnt_a, cnt_b;
    int falls[2], rises[2], nf, nr;
    logic prev_pll;
    logic [2:0] prev_st;

    // 1: power-up with lock present and NTSC requested
    repeat (3) tick();
    check("rst_pll_rst", pll_rst, 1);
    check("rst_ntsc", ntsc, 0);
    check("rst_sys_rst", sys_rst, 1);
    check("rst_state", state, 0);
    rst_n = 1'b1;
    pll_fall = -1; sys_fall = -1; ntsc_at = -1; st_at = -1;
    for (int k = 1; k <= 60 && sys_fall < 0; k++) begin
      tick();
      if (!pll_rst && pll_fall < 0) begin pll_fall = k; ntsc_at = int'(ntsc); end
      if (!sys_rst && sys_fall < 0) begin sys_fall = k; st_at = int'(state); end
    end
    check("pu_pll_fall", pll_fall, 4);
    check("pu_ntsc", ntsc_at, 1);
    check("pu_sys_fall", sys_fall, 29);
    check("pu_state", st_at, 4);

    // 2: asynchronous reset mid-run, then lock stuck low
    tick();
    rst_n = 1'b0;
    pll_locked = 1'b0;
    #1;
    check("async_state", state, 0);
    check("async_sys_rst", sys_rst, 1);
    check("async_pll_rst", pll_rst, 1);
    repeat (3) tick();
    rst_n = 1'b1;
    nf = 0; nr = 0; cnt_a = 0; cnt_b = 0; prev_pll = 1'b1;
    for (int k = 1; k <= 110; k++) begin
      tick();
      if (prev_pll && !pll_rst && nf < 2) begin falls[nf] = k; nf++; end
      if (!prev_pll && pll_rst && nr < 2) begin rises[nr] = k; nr++; end
      if (!sys_rst) cnt_a++;
      if (state > 3'd1) cnt_b++;
      prev_pll = pll_rst;
    end
    check("stuck_nfalls", nf, 2);
    check("stuck_nrises", nr, 2);
    if (nf == 2 && nr == 2) begin
      check("stuck_fall1", falls[0], 4);
      check("stuck_rise1", rises[0], 36);
      check("stuck_fall2", falls[1], 40);
      check("stuck_rise2", rises[1], 72);
    end
    check("stuck_sys_low", cnt_a, 0);
    check("stuck_bad_state", cnt_b, 0);
    pll_locked = 1'b1;
    wait_run("run_after_stuck");

    // 3: one-cycle lock glitch in RUN
    pll_locked = 1'b0;
    sys_fall = -1; first_k = -1; st_at = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 1) pll_locked = 1'b1;
      if (sys_rst && first_k < 0) begin first_k = k; st_at = int'(state); end
      if (first_k > 0 && !sys_rst && sys_fall < 0) sys_fall = k;
    end
    check("glitch_rise", first_k, 3);
    check("glitch_state", st_at, 1);
    check("glitch_fall", sys_fall, 28);
    wait_run("run_after_glitch");

    // 4: short mode toggle ignored, held mode change restarts PLL
    ntsc_sel = 1'b0;
    cnt_a = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 2) ntsc_sel = 1'b1;
      if (state != 3'd4) cnt_a++;
    end
    check("mode_glitch_ignored", cnt_a, 0);
    ntsc_sel = 1'b0;
    first_k = -1;
    for (int k = 1; k <= 12 && first_k < 0; k++) begin
      tick();
      if (state == 3'd0) begin
        first_k = k;
        check("mode_ntsc", ntsc, 0);
        check("mode_pll_rst", pll_rst, 1);
        check("mode_sys_rst", sys_rst, 1);
      end
    end
    check("mode_entry", first_k, 7);
    wait_run("run_after_mode");

    // 5: bouncing button, then long hold, then release and press again
    entries = 0; cnt_a = 0; first_k = -1; prev_st = state;
    for (int i = 0; i < 6; i++) begin
      btn_rst_n = (i % 2 == 1);
      tick();
      if (state == 3'd3 && prev_st != 3'd3) entries++;
      if (sys_rst) cnt_a++;
      prev_st = state;
    end
    btn_rst_n = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (state == 3'd3 && prev_st != 3'd3) begin
        entries++;
        if (first_k < 0) first_k = k;
      end
      if (sys_rst) cnt_a++;
      prev_st = state;
    end
    check("btn_entries", entries, 1);
    check("btn_first", first_k, 7);
    check("btn_sys_cycles", cnt_a, 16);
    btn_rst_n = 1'b1;
    repeat (10) tick();
    btn_rst_n = 1'b0;
    first_k = -1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (state == 3'd3 && first_k < 0) first_k = k;
    end
    check("btn_second", first_k, 7);
    btn_rst_n = 1'b1;
    wait_run("run_after_btn");

    // 6: lock loss, mode change and press arrive together
    ntsc_sel = 1'b1;
    btn_rst_n = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 4) pll_locked = 1'b0;
      if (k == 5) pll_locked = 1'b1;
      if (k == 7) check("combo_waitlock", state, 1);
      if (k == 8) check("combo_settle", state, 2);
      if (k == 9) begin
        check("combo_pllrst", state, 0);
        check("combo_ntsc", ntsc, 1);
        btn_rst_n = 1'b1;
      end
    end
    wait_run("run_after_combo");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
